// File: rtl/chunked_adder_if.sv
// Handshake and data bundle for chunked_adder.
// master: producer/consumer side; slave: the adder itself.
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_a_in;
  logic [WIDTH-1:0] io_b_in;
  logic             io_c_in;
  logic             io_sub;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_s;
  logic             io_cout;
  logic             io_ovf;

  modport master (
    output io_in_valid, io_a_in, io_b_in, io_c_in, io_sub, io_out_ready,
    input  io_in_ready, io_out_valid, io_s, io_cout, io_ovf
  );

  modport slave (
    input  io_in_valid, io_a_in, io_b_in, io_c_in, io_sub, io_out_ready,
    output io_in_ready, io_out_valid, io_s, io_cout, io_ovf
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle carry-propagate adder/subtractor.
// One CHUNK-wide ripple stage is reused N = WIDTH/CHUNK times; the carry
// between chunks lives in a register. Operands are shifted right each RUN
// cycle so the active chunk is always in the low bits, and result chunks
// are shifted in from the top, so after N cycles s_q holds the full result.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for operands, io_in_ready=1
// S_RUN  | resolving one chunk per cycle, inputs ignored
// S_DONE | result held on io_s/io_cout/io_ovf until io_out_ready
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clock,
  input  logic          reset,
  chunked_adder_if.slave io
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;
  logic [WIDTH-1:0] s_next;

  assign last_chunk = (k_q == K_LAST);
  assign accept     = io.io_in_valid && io.io_in_ready;

  // Single ripple stage working on the low chunk of the shifted operands.
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  // Carry into the operand MSB, recovered from its sum bit; only meaningful
  // on the last chunk, where bit CHUNK-1 of the chunk is bit WIDTH-1 overall.
  assign msb_carry_in = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];

  if (CHUNK == WIDTH) begin : g_single_chunk
    assign s_next = chunk_sum[CHUNK-1:0];
  end else begin : g_multi_chunk
    assign s_next = {chunk_sum[CHUNK-1:0], s_q[WIDTH-1:CHUNK]};
  end

  assign io.io_s    = s_q;
  assign io.io_cout = cout_q;
  assign io.io_ovf  = ovf_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; ready in DONE follows the consumer so
  // a result can be drained and a new operation accepted in one cycle.
  always_comb begin
    state_d         = state_q;
    io.io_in_ready  = 1'b0;
    io.io_out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        io.io_in_ready = 1'b1;
        if (io.io_in_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_chunk) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        io.io_out_valid = 1'b1;
        io.io_in_ready  = io.io_out_ready;
        if (io.io_out_ready) begin
          state_d = io.io_in_valid ? S_RUN : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one chunk resolved per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= io.io_a_in;
      b_q     <= io.io_sub ? ~io.io_b_in : io.io_b_in;
      carry_q <= io.io_sub ? 1'b1 : io.io_c_in;
      k_q     <= '0;
    end else if (state_q == S_RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      carry_q <= chunk_sum[CHUNK];
      s_q     <= s_next;
      k_q     <= k_q + KW'(1);
      if (last_chunk) begin
        cout_q <= chunk_sum[CHUNK];
        ovf_q  <= msb_carry_in ^ chunk_sum[CHUNK];
      end
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: default configuration plus three
// alternative parameter sets driven side by side.
module tb_chunked_adder;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  chunked_adder_if #(.WIDTH(16)) dif ();
  chunked_adder_if #(.WIDTH(16)) c1if ();
  chunked_adder_if #(.WIDTH(16)) c16if ();
  chunked_adder_if #(.WIDTH(32)) w32if ();

  chunked_adder #(.WIDTH(16), .CHUNK(4))  dut     (.clock(clock), .reset(reset), .io(dif));
  chunked_adder #(.WIDTH(16), .CHUNK(1))  dut_c1  (.clock(clock), .reset(reset), .io(c1if));
  chunked_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (.clock(clock), .reset(reset), .io(c16if));
  chunked_adder #(.WIDTH(32), .CHUNK(8))  dut_w32 (.clock(clock), .reset(reset), .io(w32if));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (dif.io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", dif.io_in_ready); end
    checks++; if (dif.io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", dif.io_out_valid); end
    checks++; if (dif.io_s !== 16'h0000) begin errors++; $display("FAIL reset_s: got %h expected 0000", dif.io_s); end
    checks++; if (dif.io_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", dif.io_cout); end
    checks++; if (dif.io_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", dif.io_ovf); end
    checks++; if ({c1if.io_out_valid, c16if.io_out_valid, w32if.io_out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_sweep_valid: got %b expected 000", {c1if.io_out_valid, c16if.io_out_valid, w32if.io_out_valid});
    end
  endtask

  // One operation on the default DUT with the consumer always ready.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    dif.io_a_in = a; dif.io_b_in = b; dif.io_c_in = c; dif.io_sub = sub;
    dif.io_in_valid = 1'b1; dif.io_out_ready = 1'b1;
    checks++; if (dif.io_in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, dif.io_in_ready); end
    tick();
    dif.io_in_valid = 1'b0;
    dif.io_a_in = ~a; dif.io_b_in = ~b; dif.io_sub = ~sub; dif.io_c_in = ~c;
    lat = 0;
    while (dif.io_out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
    checks++; if (dif.io_s !== es) begin errors++; $display("FAIL %s_s: got %h expected %h", name, dif.io_s, es); end
    checks++; if (dif.io_cout !== ec) begin errors++; $display("FAIL %s_cout: got %b expected %b", name, dif.io_cout, ec); end
    checks++; if (dif.io_ovf !== eo) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, dif.io_ovf, eo); end
    tick();
    checks++; if (dif.io_out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b expected 0", name, dif.io_out_valid); end
  endtask

  task automatic test_add;
    run_op("add_basic",    16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    run_op("add_wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_ripple",   16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_sub;
    run_op("sub_ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_borrow",   16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_equal",    16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("sub_zero_m1",  16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    int lat;
    dif.io_a_in = 16'h1111; dif.io_b_in = 16'h2222; dif.io_c_in = 1'b0; dif.io_sub = 1'b0;
    dif.io_out_ready = 1'b0; dif.io_in_valid = 1'b1;
    tick();
    dif.io_in_valid = 1'b0;
    lat = 0;
    while (dif.io_out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 10; i++) begin
      dif.io_a_in = 16'($urandom);
      dif.io_b_in = 16'($urandom);
      dif.io_sub  = i[0];
      tick();
      checks++; if (dif.io_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", dif.io_out_valid); end
      checks++; if (dif.io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready: got %b expected 0", dif.io_in_ready); end
      checks++; if (dif.io_s !== 16'h3333) begin errors++; $display("FAIL bp_hold_s: got %h expected 3333", dif.io_s); end
      checks++; if ({dif.io_cout, dif.io_ovf} !== 2'b00) begin errors++; $display("FAIL bp_hold_flags: got %b expected 00", {dif.io_cout, dif.io_ovf}); end
    end
    dif.io_a_in = 16'h0005; dif.io_b_in = 16'h0003; dif.io_sub = 1'b1; dif.io_c_in = 1'b0;
    dif.io_in_valid = 1'b1; dif.io_out_ready = 1'b1;
    #1;
    checks++; if (dif.io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", dif.io_in_ready); end
    tick();
    dif.io_in_valid = 1'b0;
    checks++; if (dif.io_out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b expected 0", dif.io_out_valid); end
    lat = 0;
    while (dif.io_out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_next_latency: got %0d expected 4", lat); end
    checks++; if (dif.io_s !== 16'h0002) begin errors++; $display("FAIL bp_next_s: got %h expected 0002", dif.io_s); end
    checks++; if ({dif.io_cout, dif.io_ovf} !== 2'b10) begin errors++; $display("FAIL bp_next_flags: got %b expected 10", {dif.io_cout, dif.io_ovf}); end
    tick();
  endtask

  task automatic test_reset_mid_run;
    dif.io_a_in = 16'h1234; dif.io_b_in = 16'h1111; dif.io_c_in = 1'b0; dif.io_sub = 1'b0;
    dif.io_out_ready = 1'b1; dif.io_in_valid = 1'b1;
    tick();
    dif.io_in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (dif.io_in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", dif.io_in_ready); end
    checks++; if (dif.io_out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", dif.io_out_valid); end
    checks++; if (dif.io_s !== 16'h0000) begin errors++; $display("FAIL abort_s: got %h expected 0000", dif.io_s); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (dif.io_out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b expected 0 at cycle %0d", dif.io_out_valid, i); end
    end
    run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
  endtask

  // One operation driven into all three alternative configurations at once.
  task automatic sweep_op(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sub);
    logic [15:0] b16;
    logic [31:0] b32;
    logic        cin;
    logic [16:0] t16;
    logic [32:0] t32;
    logic [15:0] es16;
    logic [31:0] es32;
    logic        ec16, eo16, ec32, eo32;
    int          lat1, lat16, lat32;
    logic [15:0] s1, s16;
    logic [31:0] s32;
    logic [1:0]  f1, f16, f32;

    b16  = sub ? ~b[15:0] : b[15:0];
    b32  = sub ? ~b : b;
    cin  = sub ? 1'b1 : c;
    t16  = {1'b0, a[15:0]} + {1'b0, b16} + {16'b0, cin};
    t32  = {1'b0, a} + {1'b0, b32} + {32'b0, cin};
    es16 = t16[15:0];
    ec16 = t16[16];
    eo16 = (a[15] == b16[15]) && (es16[15] != a[15]);
    es32 = t32[31:0];
    ec32 = t32[32];
    eo32 = (a[31] == b32[31]) && (es32[31] != a[31]);

    c1if.io_a_in  = a[15:0]; c1if.io_b_in  = b[15:0]; c1if.io_c_in  = c; c1if.io_sub  = sub;
    c16if.io_a_in = a[15:0]; c16if.io_b_in = b[15:0]; c16if.io_c_in = c; c16if.io_sub = sub;
    w32if.io_a_in = a;       w32if.io_b_in = b;       w32if.io_c_in = c; w32if.io_sub = sub;
    c1if.io_out_ready = 1'b1; c16if.io_out_ready = 1'b1; w32if.io_out_ready = 1'b1;
    c1if.io_in_valid = 1'b1; c16if.io_in_valid = 1'b1; w32if.io_in_valid = 1'b1;
    tick();
    c1if.io_in_valid = 1'b0; c16if.io_in_valid = 1'b0; w32if.io_in_valid = 1'b0;
    c1if.io_a_in = ~a[15:0]; c16if.io_a_in = ~a[15:0]; w32if.io_a_in = ~a;

    lat1 = -1; lat16 = -1; lat32 = -1;
    s1 = '0; s16 = '0; s32 = '0; f1 = '0; f16 = '0; f32 = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (lat1 < 0 && c1if.io_out_valid === 1'b1) begin
        lat1 = cyc; s1 = c1if.io_s; f1 = {c1if.io_cout, c1if.io_ovf};
      end
      if (lat16 < 0 && c16if.io_out_valid === 1'b1) begin
        lat16 = cyc; s16 = c16if.io_s; f16 = {c16if.io_cout, c16if.io_ovf};
      end
      if (lat32 < 0 && w32if.io_out_valid === 1'b1) begin
        lat32 = cyc; s32 = w32if.io_s; f32 = {w32if.io_cout, w32if.io_ovf};
      end
      if (lat1 >= 0 && lat16 >= 0 && lat32 >= 0) break;
      tick();
    end

    checks++; if (lat1 != 16) begin errors++; $display("FAIL c1_latency: got %0d expected 16", lat1); end
    checks++; if (s1 !== es16) begin errors++; $display("FAIL c1_s: got %h expected %h (a=%h b=%h sub=%b)", s1, es16, a[15:0], b[15:0], sub); end
    checks++; if (f1 !== {ec16, eo16}) begin errors++; $display("FAIL c1_flags: got %b expected %b", f1, {ec16, eo16}); end
    checks++; if (lat16 != 1) begin errors++; $display("FAIL c16_latency: got %0d expected 1", lat16); end
    checks++; if (s16 !== es16) begin errors++; $display("FAIL c16_s: got %h expected %h (a=%h b=%h sub=%b)", s16, es16, a[15:0], b[15:0], sub); end
    checks++; if (f16 !== {ec16, eo16}) begin errors++; $display("FAIL c16_flags: got %b expected %b", f16, {ec16, eo16}); end
    checks++; if (lat32 != 4) begin errors++; $display("FAIL w32_latency: got %0d expected 4", lat32); end
    checks++; if (s32 !== es32) begin errors++; $display("FAIL w32_s: got %h expected %h (a=%h b=%h sub=%b)", s32, es32, a, b, sub); end
    checks++; if (f32 !== {ec32, eo32}) begin errors++; $display("FAIL w32_flags: got %b expected %b", f32, {ec32, eo32}); end
  endtask

  task automatic test_param_sweep;
    sweep_op(32'h0000_1234, 32'h0000_0FFF, 1'b1, 1'b0);
    sweep_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    sweep_op(32'h8000_8000, 32'h0000_0001, 1'b0, 1'b1);
    sweep_op(32'h7FFF_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    sweep_op(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      sweep_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    dif.io_in_valid = 1'b0; dif.io_a_in = '0; dif.io_b_in = '0;
    dif.io_c_in = 1'b0; dif.io_sub = 1'b0; dif.io_out_ready = 1'b1;
    c1if.io_in_valid = 1'b0; c1if.io_a_in = '0; c1if.io_b_in = '0;
    c1if.io_c_in = 1'b0; c1if.io_sub = 1'b0; c1if.io_out_ready = 1'b1;
    c16if.io_in_valid = 1'b0; c16if.io_a_in = '0; c16if.io_b_in = '0;
    c16if.io_c_in = 1'b0; c16if.io_sub = 1'b0; c16if.io_out_ready = 1'b1;
    w32if.io_in_valid = 1'b0; w32if.io_a_in = '0; w32if.io_b_in = '0;
    w32if.io_c_in = 1'b0; w32if.io_sub = 1'b0; w32if.io_out_ready = 1'b1;

    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_param_sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
